esfa_access_arbiter: RTL

//  Shares one ESFADesign instance between two requesters (port 0: host sandbox process, port 1: local client).

---
 rtl/esfa_access_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/esfa_access_arbiter.sv
// Round-robin arbiter that shares one ESFA core between two requesters.
// Runs one command at a time (grant, issue, fixed-latency wait, response) with all outputs registered.
module esfa_access_arbiter #(
  parameter int unsigned RESULT_LAT = 2,
  parameter logic [7:0]  IDLE_SEL   = 8'd8
) (
  input  logic        masterClock,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_ctrl,
  input  logic [31:0] req0_data,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp0_bool,
  output logic [7:0]  resp0_value,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_ctrl,
  input  logic [31:0] req1_data,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic        resp1_bool,
  output logic [7:0]  resp1_value,

  output logic [7:0]  esfa_new_index,
  output logic [7:0]  esfa_new_value,
  output logic [7:0]  esfa_metadata,
  output logic        esfa_isMetadata,
  output logic [7:0]  esfa_selector,
  input  logic        esfa_resultBool,
  input  logic [7:0]  esfa_resultValue
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       gnt_q, gnt_d;
  logic                       mut_q, mut_d;
  logic                       meta_q, meta_d;
  logic [DATA_W-1:0]          data_q, data_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 req_ready_q, req_ready_d;
  logic [1:0]                 resp_valid_q, resp_valid_d;
  logic [1:0]                 resp_bool_q, resp_bool_d;
  logic [1:0][BYTE_W-1:0]     resp_value_q, resp_value_d;
  logic [BYTE_W-1:0]          idx_q, idx_d;
  logic [BYTE_W-1:0]          val_q, val_d;
  logic [BYTE_W-1:0]          mdata_q, mdata_d;
  logic                       ismeta_q, ismeta_d;
  logic [BYTE_W-1:0]          sel_q, sel_d;

  logic                       gnt_id_c;
  logic                       resp_ack_c;
  logic                       unused_ctrl;

  // Upper control bits carry no meaning for the core.
  assign unused_ctrl = ^{req0_ctrl[7:2], req1_ctrl[7:2]};

  // Tie-break toward the port that did not win last; otherwise the lone requester.
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_id_c = ~last_grant_q;
    end else begin
      gnt_id_c = req1_valid;
    end
  end

  assign resp_ack_c = gnt_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    mut_d        = mut_q;
    meta_d       = meta_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    req_ready_d  = 2'b00;
    resp_valid_d = resp_valid_q;
    resp_bool_d  = resp_bool_q;
    resp_value_d = resp_value_q;
    idx_d        = idx_q;
    val_d        = val_q;
    mdata_d      = mdata_q;
    ismeta_d     = ismeta_q;
    sel_d        = sel_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d                 = gnt_id_c;
          last_grant_d          = gnt_id_c;
          req_ready_d[gnt_id_c] = 1'b1;
          mut_d                 = gnt_id_c ? req1_ctrl[0] : req0_ctrl[0];
          meta_d                = gnt_id_c ? req1_ctrl[1] : req0_ctrl[1];
          data_d                = gnt_id_c ? req1_data : req0_data;
          state_d               = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Queries leave the field outputs untouched and only park the selector.
        if (mut_q) begin
          idx_d    = data_q[7:0];
          val_d    = data_q[15:8];
          mdata_d  = data_q[23:16];
          ismeta_d = meta_q;
          sel_d    = data_q[31:24];
        end else begin
          sel_d    = IDLE_SEL;
        end
        cnt_d   = CNT_W'(RESULT_LAT - 1);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          resp_valid_d[gnt_q] = 1'b1;
          if (mut_q) begin
            resp_bool_d[gnt_q]  = 1'b1;
            resp_value_d[gnt_q] = '0;
          end else begin
            resp_bool_d[gnt_q]  = esfa_resultBool;
            resp_value_d[gnt_q] = esfa_resultValue;
          end
          sel_d   = IDLE_SEL;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (resp_ack_c) begin
          resp_valid_d[gnt_q] = 1'b0;
          state_d             = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Synchronous active-low reset; aborts any command in flight without a response.
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      mut_q        <= 1'b0;
      meta_q       <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 2'b00;
      resp_valid_q <= 2'b00;
      resp_bool_q  <= 2'b00;
      resp_value_q <= '0;
      idx_q        <= '0;
      val_q        <= '0;
      mdata_q      <= '0;
      ismeta_q     <= 1'b0;
      sel_q        <= IDLE_SEL;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      mut_q        <= mut_d;
      meta_q       <= meta_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_bool_q  <= resp_bool_d;
      resp_value_q <= resp_value_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      mdata_q      <= mdata_d;
      ismeta_q     <= ismeta_d;
      sel_q        <= sel_d;
    end
  end

  assign req0_ready      = req_ready_q[0];
  assign req1_ready      = req_ready_q[1];
  assign resp0_valid     = resp_valid_q[0];
  assign resp1_valid     = resp_valid_q[1];
  assign resp0_bool      = resp_bool_q[0];
  assign resp1_bool      = resp_bool_q[1];
  assign resp0_value     = resp_value_q[0];
  assign resp1_value     = resp_value_q[1];
  assign esfa_new_index  = idx_q;
  assign esfa_new_value  = val_q;
  assign esfa_metadata   = mdata_q;
  assign esfa_isMetadata = ismeta_q;
  assign esfa_selector   = sel_q;

endmodule
